// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the unified memory-port arbiter.
// Master ids double as the one-bit owner field carried by the read-tag pipeline.
package mem_arb_pkg;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_LDR = 1'b1;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  localparam int TAG_W = $bits(rd_tag_t);

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep shift register of {valid, owner} tags that tracks each read
// request until its data comes back from memory.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push_valid,
  input  logic push_owner,
  output logic pop_valid,
  output logic pop_owner
);

  rd_tag_t stage [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= '{valid: push_valid, owner: push_owner};
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign pop_valid = stage[RD_LAT-1].valid;
  assign pop_owner = stage[RD_LAT-1].owner;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the unified instruction/data memory port: round-robin
// on ties, bounded burst lock for the loader, read data routed back by tag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  logic       last_owner;
  logic       locked;
  logic [7:0] burst_cnt;
  logic       pop_valid;
  logic       pop_owner;

  always_comb begin
    m1_gnt = 1'b0;
    if (!rst && m1_req) begin
      if (!m0_req)     m1_gnt = 1'b1;
      else if (locked) m1_gnt = (burst_cnt < MAX_B);
      else             m1_gnt = (last_owner == MST_CPU);
    end
    m0_gnt = !rst && m0_req && !m1_gnt;
  end

  assign mem_en    = m0_gnt | m1_gnt;
  assign mem_we    = m1_gnt ? m1_we : (m0_gnt & m0_we);
  assign mem_adr   = m1_gnt ? m1_adr : m0_adr;
  assign mem_wdata = m1_gnt ? m1_wdata : m0_wdata;

  // The locking grant itself already makes m0 wait, so it counts toward the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= MST_LDR;
      locked     <= 1'b0;
      burst_cnt  <= '0;
    end else if (m0_gnt) begin
      last_owner <= MST_CPU;
      locked     <= 1'b0;
      burst_cnt  <= '0;
    end else if (m1_gnt) begin
      last_owner <= MST_LDR;
      locked     <= m1_lock;
      if (!m1_lock)
        burst_cnt <= '0;
      else if (m0_req && burst_cnt < MAX_B)
        burst_cnt <= burst_cnt + 8'd1;
    end else if (!m1_lock) begin
      locked    <= 1'b0;
      burst_cnt <= '0;
    end
  end

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_rd_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .push_valid (mem_en & ~mem_we),
    .push_owner (m1_gnt),
    .pop_valid  (pop_valid),
    .pop_owner  (pop_owner)
  );

  assign m0_rvalid = !rst && pop_valid && (pop_owner == MST_CPU);
  assign m1_rvalid = !rst && pop_valid && (pop_owner == MST_LDR);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters with RD_LAT=1,2,3 (MAX_BURST=3) share stimulus,
// each backed by its own small memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_adr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [31:0] m1_adr = '0, m1_wdata = '0;

  logic        m0_gnt [3];
  logic        m0_rvalid [3];
  logic [31:0] m0_rdata [3];
  logic        m1_gnt [3];
  logic        m1_rvalid [3];
  logic [31:0] m1_rdata [3];
  logic        mem_en [3];
  logic        mem_we [3];
  logic [31:0] mem_adr [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] mem_arr [256];
    logic [31:0] rpipe [4];

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(g + 1), .MAX_BURST(3)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_adr    (m0_adr),
      .m0_wdata  (m0_wdata),
      .m0_gnt    (m0_gnt[g]),
      .m0_rvalid (m0_rvalid[g]),
      .m0_rdata  (m0_rdata[g]),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_lock   (m1_lock),
      .m1_adr    (m1_adr),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt[g]),
      .m1_rvalid (m1_rvalid[g]),
      .m1_rdata  (m1_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_adr   (mem_adr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );

    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
        mem_arr[1]  <= 32'h11110004;
        mem_arr[2]  <= 32'h22220008;
        mem_arr[3]  <= 32'h3333000C;
        mem_arr[4]  <= 32'hDEADBEEF;
        mem_arr[64] <= 32'hCAFE0100;
      end else if (mem_en[g] && mem_we[g]) begin
        mem_arr[mem_adr[g][9:2]] <= mem_wdata[g];
      end
      rpipe[0] <= mem_arr[mem_adr[g][9:2]];
      for (int k = 1; k < 4; k++) rpipe[k] <= rpipe[k-1];
    end

    assign mem_rdata[g] = rpipe[g];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_adr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       e1;
    logic [3:0] alt_m1;
    logic [8:0] lock_m1;
    logic [5:0] t4_r0, t4_r1, t4_rv0, t4_rv1;
    logic [31:0] t4_d [6];

    // reset gating: requests high, everything must stay 0
    m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
    cyc();
    #2;
    chk("reset_outs", {m0_gnt[0], m1_gnt[0], m0_rvalid[0], m1_rvalid[0], mem_en[0], mem_we[0]}, '0);
    cyc();
    idle_inputs();
    rst = 1'b0;

    // single m0 read, RD_LAT=1
    m0_req = 1'b1; m0_adr = 32'h10;
    #2;
    chk("rd1_gnt", {m0_gnt[0], m1_gnt[0], mem_en[0], mem_we[0], mem_adr[0]}, {4'b1010, 32'h10});
    cyc();
    m0_req = 1'b0;
    #2;
    chk("rd1_rvalid", {m0_rvalid[0], m1_rvalid[0], m0_rdata[0], m1_rdata[0]}, {2'b10, 32'hDEADBEEF, 32'h0});
    cyc();
    #2;
    chk("rd1_done", {m0_rvalid[0], m1_rvalid[0]}, 2'b00);

    // round-robin, no lock
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; m0_adr = 32'h20; m1_adr = 32'h40;
    alt_m1 = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #2;
      e1 = alt_m1[k];
      chk($sformatf("alt_%0d", k), {m0_gnt[0], m1_gnt[0], mem_adr[0]}, {~e1, e1, e1 ? 32'h40 : 32'h20});
      cyc();
    end

    // burst lock, MAX_BURST=3
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; m1_lock = 1'b1; m0_adr = 32'h20; m1_adr = 32'h40;
    lock_m1 = 9'b011101110;
    for (int k = 0; k < 9; k++) begin
      #2;
      e1 = lock_m1[k];
      chk($sformatf("lock_%0d", k), {m0_gnt[0], m1_gnt[0]}, {~e1, e1});
      cyc();
    end
    idle_inputs();

    // RD_LAT=2 back-to-back reads m0,m1,m0
    do_reset();
    t4_r0  = 6'b000101;
    t4_r1  = 6'b000010;
    t4_rv0 = 6'b010100;
    t4_rv1 = 6'b001000;
    t4_d[0] = 32'h0; t4_d[1] = 32'h0; t4_d[2] = 32'h11110004;
    t4_d[3] = 32'h22220008; t4_d[4] = 32'h3333000C; t4_d[5] = 32'h0;
    for (int k = 0; k < 6; k++) begin
      m0_req = t4_r0[k]; m1_req = t4_r1[k];
      m0_adr = (k == 0) ? 32'h4 : 32'hC;
      m1_adr = 32'h8;
      #2;
      chk($sformatf("lat2_%0d", k), {m0_rvalid[1], m1_rvalid[1], m0_rdata[1], m1_rdata[1]},
          {t4_rv0[k], t4_rv1[k], t4_rv0[k] ? t4_d[k] : 32'h0, t4_rv1[k] ? t4_d[k] : 32'h0});
      cyc();
    end
    idle_inputs();

    // m1 write then m0 read of the same address
    do_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_adr = 32'h100; m1_wdata = 32'h12345678;
    #2;
    chk("wr_cycle", {m1_gnt[0], mem_en[0], mem_we[0], mem_adr[0], mem_wdata[0]}, {3'b111, 32'h100, 32'h12345678});
    cyc();
    idle_inputs();
    m0_req = 1'b1; m0_adr = 32'h100;
    #2;
    chk("rd_after_wr", {m0_gnt[0], mem_en[0], mem_we[0], m0_rvalid[0], m1_rvalid[0]}, 5'b11000);
    cyc();
    m0_req = 1'b0;
    #2;
    chk("rd_after_wr_data", {m0_rvalid[0], m1_rvalid[0], m0_rdata[0]}, {2'b10, 32'h12345678});
    cyc();

    // reset with two reads in flight, RD_LAT=3
    do_reset();
    m0_req = 1'b1; m0_adr = 32'h4;
    #2;
    chk("flush_gnt0", m0_gnt[2], 1'b1);
    cyc();
    m0_req = 1'b0; m1_req = 1'b1; m1_adr = 32'h8;
    #2;
    chk("flush_gnt1", m1_gnt[2], 1'b1);
    cyc();
    m1_req = 1'b0;
    #2;
    rst = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
    #1;
    chk("flush_async", {m0_gnt[2], m1_gnt[2], m0_rvalid[2], m1_rvalid[2], mem_en[2], mem_we[2]}, '0);
    cyc();
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("flush_norv_%0d", k), {m0_rvalid[2], m1_rvalid[2]}, 2'b00);
      cyc();
    end
    m0_req = 1'b1; m1_req = 1'b1;
    #2;
    chk("flush_tie", {m0_gnt[2], m1_gnt[2]}, 2'b10);
    cyc();
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
